pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Receive-side counterpart of the motor PWM generator.
- Measures an incoming PWM waveform (motor drive loopback, servo/RC command, or tach line) and reports period, high time, and a 10-bit duty code on the same 0..1023 scale the generator takes as input.
- Sits between an input pin and the control logic. Uses a sequential divider and a stall-detect timeout.

Parameters:
- CNT_W, 16: width of the period and high-time counters and outputs.
- TIMEOUT_CYC, 8192: clk cycles without a rising edge before timeout is declared. Must be < 2^CNT_W.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset, asynchronous, active-low
- pwm_in  in  1  asynchronous PWM input
- duty  out  10  floor(high_time*1024/period); 0 or 1023 on timeout
- period  out  CNT_W  clk cycles between consecutive rising edges
- high_time  out  CNT_W  clk cycles from a rising edge to the following falling edge
- valid  out  1  one-cycle pulse when duty/period/high_time/timeout update
- timeout  out  1  level; no rising edge for TIMEOUT_CYC cycles

Behaviour:
- Reset (rst=0, async):
  - duty, period, high_time = 0; valid = 0; timeout = 0.
  - 2-FF synchronizer = 0; FSM = IDLE; all counters = 0.
  - Reset during DIVIDE aborts the division; no valid is issued.
- Input conditioning:
  - 2-FF synchronizer produces s. s_d = s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d. All timing refers to detection cycles.
- Counters:
  - per_cnt counts every cycle since the last rise. It is set to 1 on the cycle after a rise.
  - hi_cnt counts while s=1 since the last rise and freezes at fall.
  - Both saturate at 2^CNT_W-1.
- FSM states IDLE, MEASURE, DIVIDE:
  - IDLE: wait for rise -> MEASURE, counters restart. Outputs hold.
  - MEASURE, rise: snapshot P = per_cnt and H = hi_cnt, restart counters, -> DIVIDE.
  - DIVIDE: 10-iteration restoring division.
    - Remainder starts at H, quotient q = 0.
    - Each cycle: rem = rem<<1; if rem >= P then rem -= P and set q bit = 1.
    - H < P always, so q fits 10 bits.
    - After 10 cycles: period <= P, high_time <= H, duty <= q, timeout <= 0, valid = 1 for one cycle -> MEASURE.
  - Latency: valid asserts 11 cycles after the rise detection cycle that closed the period.
  - Rise during DIVIDE: the period ending at that rise is discarded (no snapshot). Counters restart normally, so the next period is measured.
  - Counting continues during DIVIDE.
- Timeout (checked in MEASURE and IDLE-after-measure):
  - Triggers when per_cnt reaches TIMEOUT_CYC.
  - Sets timeout = 1, period = 0, high_time = 0, duty = (s ? 1023 : 0); valid pulses once; -> IDLE.
  - In IDLE, timeout holds and is not re-pulsed.
  - Recovery requires two rises, after which the normal valid clears timeout.
- Outputs are registered and change only on the valid cycle, or on reset.

Test Plan:
- 25 kHz input, high 2929 / low 1072 cycles -> period=4001, high_time=2929, duty=749; valid every 4001 cycles, 11 cycles after each rise.
- 50% input, high 2000 / low 2000 -> period=4000, high_time=2000, duty=512, timeout=0.
- Run 50% input, then hold pwm_in low -> timeout=1, duty=0, period=0, single valid, TIMEOUT_CYC cycles after the last rise; no further valid until two new rises.
- pwm_in held high from reset release -> first rise enters MEASURE; after TIMEOUT_CYC: timeout=1, duty=1023, one valid.
- Fast input, high 3 / low 5 -> period=8, high_time=3, duty=384.
  - The rise 8 cycles into DIVIDE is dropped, so valid occurs every 16 cycles.
  - No corrupted values appear.
- Assert rst mid-DIVIDE -> all outputs 0 immediately, no valid. After release, the first valid appears only after two rises.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time between synchronized rising
// edges and reports a 10-bit duty code (0..1023) through a restoring divider.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 8192
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [9:0]       duty,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       LAST_ITER = 4'd9;

  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

  state_t           state_reg, state_next;
  logic             sync1_reg, s_reg, s_d_reg;
  logic             rise, fall;
  logic [CNT_W-1:0] per_cnt_reg, hi_cnt_reg;
  logic             hi_run_reg;
  logic [CNT_W-1:0] p_snap_reg, h_snap_reg, rem_reg;
  logic [8:0]       q_reg;
  logic [3:0]       iter_reg;
  logic [CNT_W:0]   rem_shift;
  logic [CNT_W-1:0] rem_sub;
  logic             rem_ge;
  logic             start_div, finish_div, fire_timeout;
  logic [9:0]       duty_reg;
  logic [CNT_W-1:0] period_reg, high_time_reg;
  logic             valid_reg, timeout_reg;

  assign rise = s_reg & ~s_d_reg;
  assign fall = ~s_reg & s_d_reg;

  // rem < P always holds, so the subtraction result fits in CNT_W bits.
  assign rem_shift = {rem_reg, 1'b0};
  assign rem_ge    = (rem_shift >= {1'b0, p_snap_reg});
  assign rem_sub   = rem_shift[CNT_W-1:0] - p_snap_reg;

  always_comb begin
    state_next   = state_reg;
    start_div    = 1'b0;
    finish_div   = 1'b0;
    fire_timeout = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rise) state_next = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          start_div  = 1'b1;
          state_next = DIVIDE;
        end else if (per_cnt_reg == TO_LAST) begin
          fire_timeout = 1'b1;
          state_next   = IDLE;
        end
      end
      DIVIDE: begin
        if (iter_reg == LAST_ITER) begin
          finish_div = 1'b1;
          state_next = MEASURE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg     <= 1'b0;
      s_reg         <= 1'b0;
      s_d_reg       <= 1'b0;
      per_cnt_reg   <= '0;
      hi_cnt_reg    <= '0;
      hi_run_reg    <= 1'b0;
      p_snap_reg    <= '0;
      h_snap_reg    <= '0;
      rem_reg       <= '0;
      q_reg         <= '0;
      iter_reg      <= '0;
      duty_reg      <= '0;
      period_reg    <= '0;
      high_time_reg <= '0;
      valid_reg     <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      sync1_reg <= pwm_in;
      s_reg     <= sync1_reg;
      s_d_reg   <= s_reg;

      // Counters restart on every rise, including rises dropped during DIVIDE.
      if (rise)                       per_cnt_reg <= CNT_W'(1);
      else if (per_cnt_reg != CNT_MAX) per_cnt_reg <= per_cnt_reg + 1'b1;

      if (rise) begin
        hi_cnt_reg <= CNT_W'(1);
        hi_run_reg <= 1'b1;
      end else if (fall) begin
        hi_run_reg <= 1'b0;
      end else if (hi_run_reg && hi_cnt_reg != CNT_MAX) begin
        hi_cnt_reg <= hi_cnt_reg + 1'b1;
      end

      if (start_div) begin
        p_snap_reg <= per_cnt_reg;
        h_snap_reg <= hi_cnt_reg;
        rem_reg    <= hi_cnt_reg;
        q_reg      <= '0;
        iter_reg   <= '0;
      end else if (state_reg == DIVIDE) begin
        rem_reg  <= rem_ge ? rem_sub : rem_shift[CNT_W-1:0];
        q_reg    <= {q_reg[7:0], rem_ge};
        iter_reg <= iter_reg + 1'b1;
      end

      valid_reg <= 1'b0;
      if (finish_div) begin
        period_reg    <= p_snap_reg;
        high_time_reg <= h_snap_reg;
        duty_reg      <= {q_reg, rem_ge};
        timeout_reg   <= 1'b0;
        valid_reg     <= 1'b1;
      end else if (fire_timeout) begin
        period_reg    <= '0;
        high_time_reg <= '0;
        duty_reg      <= s_reg ? 10'd1023 : 10'd0;
        timeout_reg   <= 1'b1;
        valid_reg     <= 1'b1;
      end
    end
  end

  assign duty      = duty_reg;
  assign period    = period_reg;
  assign high_time = high_time_reg;
  assign valid     = valid_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: event-level model (rise/fall cycles, integer division)
// checked every cycle, plus directed literal expectations for each scenario.
module tb_pwm_capture;
  localparam int CNT_W = 16;
  localparam int TO    = 8192;

  logic             clk = 1'b0;
  logic             rst;
  logic             pwm_in;
  logic [9:0]       duty;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             timeout;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .duty(duty), .period(period),
    .high_time(high_time), .valid(valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit hist [0:131071];
  int last_rst = -1;

  // Model state: measuring flag, divider-busy window, last rise/fall, pending result.
  bit m_meas = 0;
  int m_busy_end = -100, m_last_rise = 0, m_fall = -1, m_due = -1;
  int m_pp = 0, m_ph = 0, m_pd = 0;
  logic [9:0]       e_duty = '0;
  logic [CNT_W-1:0] e_period = '0, e_high = '0;
  logic             e_valid = 1'b0, e_timeout = 1'b0;

  int last_valid = -1, prev_valid = -1, valid_cnt = 0;

  // Synchronized input level seen by the design in cycle c (two-stage delay, zero after reset).
  function automatic bit s_at(input int c);
    if (c < 2 || c - 2 <= last_rst) return 1'b0;
    return hist[(c - 2) % 131072];
  endfunction

  always @(negedge clk) begin : model
    bit sn, sp;
    cyc++;
    hist[cyc % 131072] = pwm_in;
    if (!rst) begin
      last_rst = cyc;
      m_meas = 0; m_busy_end = -100; m_last_rise = 0; m_fall = -1; m_due = -1;
      e_duty = '0; e_period = '0; e_high = '0; e_valid = 1'b0; e_timeout = 1'b0;
    end else begin
      sn = s_at(cyc);
      sp = s_at(cyc - 1);
      e_valid = 1'b0;
      if (m_due == cyc) begin
        e_period = CNT_W'(m_pp); e_high = CNT_W'(m_ph); e_duty = 10'(m_pd);
        e_timeout = 1'b0; e_valid = 1'b1; m_due = -1;
      end
      if (m_meas && m_busy_end < cyc - 1 && cyc == m_last_rise + TO) begin
        e_timeout = 1'b1; e_period = '0; e_high = '0;
        e_duty = sp ? 10'd1023 : 10'd0; e_valid = 1'b1; m_meas = 0;
      end
      if (sn && !sp) begin
        if (!m_meas) begin
          m_meas = 1;
        end else if (m_busy_end < cyc) begin
          m_pp = cyc - m_last_rise;
          m_ph = m_fall - m_last_rise;
          m_pd = (m_ph * 1024) / m_pp;
          m_due = cyc + 11;
          m_busy_end = cyc + 10;
        end
        m_last_rise = cyc;
        m_fall = -1;
      end
      if (!sn && sp) m_fall = cyc;
    end

    vectors++;
    if (valid !== e_valid || timeout !== e_timeout || duty !== e_duty ||
        period !== e_period || high_time !== e_high) begin
      miscompares++;
      $display("FAIL cycle %0d: got valid=%0b timeout=%0b duty=%0d period=%0d high_time=%0d, want valid=%0b timeout=%0b duty=%0d period=%0d high_time=%0d",
               cyc, valid, timeout, duty, period, high_time,
               e_valid, e_timeout, e_duty, e_period, e_high);
    end
    if (valid === 1'b1) begin
      prev_valid = last_valid;
      last_valid = cyc;
      valid_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive n periods; d returns the cycle in which the last rising level was driven.
  task automatic drive_pwm(input int hi, input int lo, input int n, output int d);
    d = 0;
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      d = cyc + 1;
      cycles(hi);
      pwm_in = 1'b0;
      cycles(lo);
    end
  endtask

  task automatic check_outputs(input string tag, input int p, input int h, input int dt, input int to);
    check({tag, "_period"}, int'(period), p);
    check({tag, "_high_time"}, int'(high_time), h);
    check({tag, "_duty"}, int'(duty), dt);
    check({tag, "_timeout"}, int'(timeout), to);
  endtask

  initial begin
    int d, vc, rel;
    rst = 1'b1;
    pwm_in = 1'b0;
    #2 rst = 1'b0;
    cycles(5);
    check_outputs("reset", 0, 0, 0, 0);
    check("reset_valid", int'(valid), 0);
    rst = 1'b1;
    cycles(3);

    // 25 kHz, 2929 high / 1072 low
    drive_pwm(2929, 1072, 4, d);
    check_outputs("t25k", 4001, 2929, 749, 0);
    check("t25k_spacing", last_valid - prev_valid, 4001);
    check("t25k_latency", last_valid, d + 13);

    // 50 % duty
    drive_pwm(2000, 2000, 3, d);
    check_outputs("t50", 4000, 2000, 512, 0);

    // hold low -> timeout
    vc = valid_cnt;
    cycles(TO + 30);
    check_outputs("tlow", 0, 0, 0, 1);
    check("tlow_valid_count", valid_cnt - vc, 1);
    check("tlow_latency", last_valid, d + 2 + TO);

    // recovery needs two rises
    vc = valid_cnt;
    drive_pwm(2000, 2000, 1, d);
    check("trec_one_rise_valids", valid_cnt - vc, 0);
    check("trec_one_rise_timeout", int'(timeout), 1);
    drive_pwm(2000, 2000, 1, d);
    cycles(20);
    check("trec_valid_count", valid_cnt - vc, 1);
    check_outputs("trec", 4000, 2000, 512, 0);

    // held high from reset release
    rst = 1'b0;
    pwm_in = 1'b1;
    cycles(3);
    check_outputs("reset2", 0, 0, 0, 0);
    rst = 1'b1;
    rel = cyc + 1;
    vc = valid_cnt;
    cycles(TO + 40);
    check_outputs("thigh", 0, 0, 1023, 1);
    check("thigh_valid_count", valid_cnt - vc, 1);
    check("thigh_latency", last_valid, rel + 2 + TO);

    // fast input 3 high / 5 low: every other rise falls inside DIVIDE
    pwm_in = 1'b0;
    cycles(10);
    vc = valid_cnt;
    drive_pwm(3, 5, 12, d);
    check_outputs("tfast", 8, 3, 384, 0);
    check("tfast_spacing", last_valid - prev_valid, 16);
    check("tfast_valid_count", valid_cnt - vc, 5);
    check("tfast_latency", last_valid, d - 16 + 13);

    // reset while the divider for the last accepted rise is running
    vc = valid_cnt;
    rst = 1'b0;
    cycles(2);
    check_outputs("tabort", 0, 0, 0, 0);
    check("tabort_valids", valid_cnt - vc, 0);
    rst = 1'b1;
    cycles(2);
    drive_pwm(3, 5, 1, d);
    check("tabort_one_rise_valids", valid_cnt - vc, 0);
    drive_pwm(3, 5, 2, d);
    cycles(5);
    check("tabort_valid_count", valid_cnt - vc, 1);
    check_outputs("tabort_after", 8, 3, 384, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
